// File: rtl/id_hazard_ctrl_pkg.sv
// Shared opcode/function codes and ID-stage FSM encodings for the decode front end.
// Latency: n/a (definitions only); backpressure: n/a.
package id_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_SRL = 6'h02;
    localparam logic [5:0] FUNC_SRA = 6'h03;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_XOR = 6'h26;

    typedef enum logic [1:0] {
        ID_ST_FILL  = 2'd0,
        ID_ST_RUN   = 2'd1,
        ID_ST_STALL = 2'd2
    } id_state_e;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Signal bundle between fetch/EX/MEM/regfile and the ID hazard controller.
// id_stall_cnt is present only when ID_STALL_CNT_EN is defined.
interface id_hazard_ctrl_if #(
    parameter int PC_W = 32
`ifdef ID_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
);
    logic [31:0]     if_inst;
    logic [PC_W-1:0] if_pc4;
    logic [31:0]     rf_qa;
    logic [31:0]     rf_qb;
    logic            ex_wreg;
    logic [4:0]      ex_rd;
    logic            mem_wreg;
    logic [4:0]      mem_rd;
    logic [31:0]     id_inst;
    logic [PC_W-1:0] id_pc4;
    logic            id_valid;
    logic            id_bubble;
    logic            id_wpcir;
    logic            ctrl_branch;
    logic [PC_W-1:0] nid_pc;
    logic [1:0]      id_state;
`ifdef ID_STALL_CNT_EN
    logic [CNT_W-1:0] id_stall_cnt;
`endif

    modport slave (
`ifdef ID_STALL_CNT_EN
        output id_stall_cnt,
`endif
        input  if_inst, if_pc4, rf_qa, rf_qb, ex_wreg, ex_rd, mem_wreg, mem_rd,
        output id_inst, id_pc4, id_valid, id_bubble, id_wpcir, ctrl_branch, nid_pc, id_state
    );

    modport master (
`ifdef ID_STALL_CNT_EN
        input  id_stall_cnt,
`endif
        output if_inst, if_pc4, rf_qa, rf_qb, ex_wreg, ex_rd, mem_wreg, mem_rd,
        input  id_inst, id_pc4, id_valid, id_bubble, id_wpcir, ctrl_branch, nid_pc, id_state
    );

endinterface

// File: rtl/id_hazard_ctrl_src_decode.sv
// Combinational source-operand and branch-class decode of the instruction held in IF/ID.
// Latency: 0 cycles; backpressure: none.
module id_src_decode
    import id_hazard_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [31:0]  inst,
    output logic         uses_rs,
    output logic         uses_rt,
    output logic         is_beq,
    output logic         is_bne,
    output logic         is_j,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [25:0]  j_idx,
    output logic [W-1:0] imm_sext
);

    logic [5:0] op;
    logic [5:0] func;

    assign op       = inst[31:26];
    assign func     = inst[5:0];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign j_idx    = inst[25:0];
    assign imm_sext = {{(W-16){inst[15]}}, inst[15:0]};

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        case (op)
            OP_RTYPE: begin
                // Shifts take their operand from rt and the amount from shamt.
                uses_rs = !(func == FUNC_SLL || func == FUNC_SRL || func == FUNC_SRA);
                uses_rt = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
                uses_rs = 1'b1;
            end
            OP_SW: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            OP_BNE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_bne  = 1'b1;
            end
            OP_J: begin
                is_j = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// IF/ID register, EX/MEM RAW hazard stall, and ID-stage BEQ/BNE/J resolution with IF/ID flush.
// Stall/branch outputs are same-cycle combinational; optional stall counter under ID_STALL_CNT_EN.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int PC_W = 32
`ifdef ID_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input logic             clk,
    input logic             rst,
    id_hazard_ctrl_if.slave bus
);

    logic [31:0]     inst_q, inst_d;
    logic [PC_W-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    id_state_e       state_q, state_d;

    logic            uses_rs, uses_rt, is_beq, is_bne, is_j;
    logic [4:0]      rs, rt;
    logic [25:0]     j_idx;
    logic [PC_W-1:0] imm_sext;

    id_src_decode #(.W(PC_W)) u_dec (
        .inst     (inst_q),
        .uses_rs  (uses_rs),
        .uses_rt  (uses_rt),
        .is_beq   (is_beq),
        .is_bne   (is_bne),
        .is_j     (is_j),
        .rs       (rs),
        .rt       (rt),
        .j_idx    (j_idx),
        .imm_sext (imm_sext)
    );

    // WB is not compared: the register file writes in the first half-cycle.
    logic rs_hz, rt_hz, hz;
    assign rs_hz = uses_rs && (rs != 5'd0) &&
                   ((bus.ex_wreg && bus.ex_rd == rs) || (bus.mem_wreg && bus.mem_rd == rs));
    assign rt_hz = uses_rt && (rt != 5'd0) &&
                   ((bus.ex_wreg && bus.ex_rd == rt) || (bus.mem_wreg && bus.mem_rd == rt));
    assign hz    = valid_q && (rs_hz || rt_hz);

    logic            operands_eq, resolve, taken;
    logic [PC_W-1:0] br_tgt, j_tgt;
    assign operands_eq = (bus.rf_qa == bus.rf_qb);
    assign resolve     = valid_q && !hz;
    assign taken       = resolve && ((is_beq && operands_eq) || (is_bne && !operands_eq) || is_j);
    assign br_tgt      = pc4_q + imm_sext;
    assign j_tgt       = {pc4_q[PC_W-1:26], j_idx};

    assign bus.id_inst     = inst_q;
    assign bus.id_pc4      = pc4_q;
    assign bus.id_valid    = valid_q;
    assign bus.id_state    = state_q;
    assign bus.id_wpcir    = hz;
    assign bus.id_bubble   = hz || !valid_q;
    assign bus.ctrl_branch = taken;
    assign bus.nid_pc      = !taken ? '0 : (is_j ? j_tgt : br_tgt);

    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (!hz) begin
            if (taken) begin
                inst_d  = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end else begin
                inst_d  = bus.if_inst;
                pc4_d   = bus.if_pc4;
                valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ID_ST_FILL:  state_d = ID_ST_RUN;
            ID_ST_RUN:   state_d = hz ? ID_ST_STALL : ID_ST_RUN;
            ID_ST_STALL: state_d = hz ? ID_ST_STALL : ID_ST_RUN;
            default:     state_d = ID_ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            state_q <= ID_ST_FILL;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hz && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.id_stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Random-program bench: ISA-level trace with scoreboard issue timing against the ID hazard controller.
module tb_id_hazard_ctrl;
    import id_hazard_ctrl_pkg::*;

    localparam int PC_W = 32;
`ifdef ID_STALL_CNT_EN
    localparam int CNT_W = 16;
`endif
    localparam int NTR = 300;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_hazard_ctrl_if #(
        .PC_W(PC_W)
`ifdef ID_STALL_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) bus ();

    id_hazard_ctrl #(
        .PC_W(PC_W)
`ifdef ID_STALL_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
        int          gap;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] imem[64];
    logic [31:0] regs[32];
    logic [31:0] pc;
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_stalls = 0;
    logic        running = 1'b0;

    assign bus.if_inst = imem[pc[5:0]];
    assign bus.if_pc4  = pc + 32'd1;
    assign bus.rf_qa   = regs[bus.id_inst[25:21]];
    assign bus.rf_qb   = regs[bus.id_inst[20:16]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic f_uses_rs(input logic [31:0] i);
        case (i[31:26])
            OP_RTYPE: return !(i[5:0] == FUNC_SLL || i[5:0] == FUNC_SRL || i[5:0] == FUNC_SRA);
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f_uses_rt(input logic [31:0] i);
        case (i[31:26])
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {writes, dest}
    function automatic logic [5:0] f_dest(input logic [31:0] i);
        case (i[31:26])
            OP_RTYPE: return {1'b1, i[15:11]};
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_LUI: return {1'b1, i[20:16]};
            default: return 6'd0;
        endcase
    endfunction

    task automatic gen_program();
        for (int i = 0; i < 63; i++) begin
            logic [4:0]  a, b, d;
            logic [15:0] imm, off;
            int          tgt;
            a   = 5'($urandom_range(0, 4));
            b   = 5'($urandom_range(0, 4));
            d   = 5'($urandom_range(0, 4));
            imm = 16'($urandom);
            tgt = $urandom_range(0, 62);
            off = 16'(tgt - (i + 1));
            case ($urandom_range(0, 13))
                0, 1: imem[i] = {OP_RTYPE, a, b, d, 5'd0, FUNC_ADD};
                2:    imem[i] = {OP_RTYPE, a, b, d, 5'd0, FUNC_SUB};
                3:    imem[i] = {OP_RTYPE, a, b, d, 5'd0, FUNC_OR};
                4:    imem[i] = {OP_RTYPE, a, b, d, 5'd3, FUNC_SLL};
                5:    imem[i] = {OP_ADDI, a, b, imm};
                6:    imem[i] = {OP_ORI, a, b, imm};
                7:    imem[i] = {OP_LW, a, b, imm};
                8:    imem[i] = {OP_SW, a, b, imm};
                9:    imem[i] = {OP_BEQ, a, b, off};
                10:   imem[i] = {OP_BNE, a, b, off};
                11:   imem[i] = {OP_J, 26'(tgt)};
                12:   imem[i] = {OP_LUI, a, b, imm};
                default: imem[i] = {OP_RTYPE, a, b, d, 5'd0, FUNC_AND};
            endcase
        end
        imem[63] = {OP_J, 26'd0};
    endtask

    // Architectural execution in program order; issue time of each instruction is the
    // later of its in-order slot and three cycles after the last writer of any source.
    task automatic build_trace();
        logic [31:0] p, inst;
        logic [5:0]  dst;
        logic [4:0]  s, t2;
        int          t, tprev, nat;
        logic        prev_tk;
        int          lastw[32];
        exp_t        e;
        foreach (lastw[r]) lastw[r] = -100;
        p = 0; tprev = 0; prev_tk = 1'b0;
        for (int k = 0; k < NTR; k++) begin
            inst = imem[p[5:0]];
            s    = inst[25:21];
            t2   = inst[20:16];
            nat  = (k == 0) ? 0 : tprev + 1 + (prev_tk ? 1 : 0);
            t    = nat;
            if (f_uses_rs(inst) && s != 0 && lastw[s] + 3 > t) t = lastw[s] + 3;
            if (f_uses_rt(inst) && t2 != 0 && lastw[t2] + 3 > t) t = lastw[t2] + 3;
            exp_stalls += t - nat;
            e.inst  = inst;
            e.pc4   = p + 32'd1;
            e.gap   = t - tprev;
            e.taken = 1'b0;
            e.tgt   = 32'd0;
            case (inst[31:26])
                OP_BEQ: e.taken = (regs[s] == regs[t2]);
                OP_BNE: e.taken = (regs[s] != regs[t2]);
                OP_J:   e.taken = 1'b1;
                default: e.taken = 1'b0;
            endcase
            if (inst[31:26] == OP_J) e.tgt = {e.pc4[31:26], inst[25:0]};
            else if (e.taken)        e.tgt = e.pc4 + {{16{inst[15]}}, inst[15:0]};
            exp_q.push_back(e);
            dst = f_dest(inst);
            if (dst[5] && dst[4:0] != 5'd0) lastw[dst[4:0]] = t;
            tprev   = t;
            prev_tk = e.taken;
            p       = e.taken ? e.tgt : p + 32'd1;
        end
    endtask

    // Fetch stage plus EX/MEM destination pipeline around the DUT.
    initial begin
        logic        s_wpcir, s_br, s_bub, r;
        logic [31:0] s_nid, s_inst;
        logic [5:0]  ex_v, mem_v;
        ex_v = 6'd0;
        forever begin
            @(negedge clk);
            s_wpcir = bus.id_wpcir;
            s_br    = bus.ctrl_branch;
            s_nid   = bus.nid_pc;
            s_bub   = bus.id_bubble;
            s_inst  = bus.id_inst;
            @(posedge clk);
            r = rst;
            #1;
            if (r) begin
                pc    = 32'd0;
                ex_v  = 6'd0;
                mem_v = 6'd0;
            end else begin
                pc    = s_wpcir ? pc : (s_br ? s_nid : pc + 32'd1);
                mem_v = ex_v;
                ex_v  = s_bub ? 6'd0 : f_dest(s_inst);
            end
            bus.ex_wreg  = ex_v[5];
            bus.ex_rd    = ex_v[4:0];
            bus.mem_wreg = mem_v[5];
            bus.mem_rd   = mem_v[4:0];
        end
    end

    // Monitor: every cycle an instruction leaves ID, pop and compare.
    initial begin
        int   cyc, last;
        logic first;
        exp_t e;
        cyc = 0; last = 0; first = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cyc++;
                if (running && !bus.id_bubble && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("issue_inst", 64'(bus.id_inst), 64'(e.inst));
                    chk("issue_pc4", 64'(bus.id_pc4), 64'(e.pc4));
                    chk("issue_valid", 64'(bus.id_valid), 64'd1);
                    chk("wpcir_at_issue", 64'(bus.id_wpcir), 64'd0);
                    chk("ctrl_branch", 64'(bus.ctrl_branch), 64'(e.taken));
                    if (e.taken) chk("nid_pc", 64'(bus.nid_pc), 64'(e.tgt));
                    if (!first) chk("issue_gap", 64'(cyc - last), 64'(e.gap));
                    first = 1'b0;
                    last  = cyc;
`ifdef ID_STALL_CNT_EN
                    if (exp_q.size() == 0) chk("stall_cnt", 64'(bus.id_stall_cnt), 64'(exp_stalls));
`endif
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_id_inst"}, 64'(bus.id_inst), 64'd0);
        chk({tag, "_id_pc4"}, 64'(bus.id_pc4), 64'd0);
        chk({tag, "_id_valid"}, 64'(bus.id_valid), 64'd0);
        chk({tag, "_id_state"}, 64'(bus.id_state), 64'd0);
        chk({tag, "_id_wpcir"}, 64'(bus.id_wpcir), 64'd0);
        chk({tag, "_ctrl_branch"}, 64'(bus.ctrl_branch), 64'd0);
        chk({tag, "_nid_pc"}, 64'(bus.nid_pc), 64'd0);
        chk({tag, "_id_bubble"}, 64'(bus.id_bubble), 64'd1);
`ifdef ID_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, 64'(bus.id_stall_cnt), 64'd0);
`endif
    endtask

    initial begin
        logic found;
        foreach (regs[i]) regs[i] = 32'($urandom_range(0, 2));
        regs[0] = 32'd0;
        pc = 32'd0;
        bus.ex_wreg = 1'b0;
        bus.ex_rd = 5'd0;
        bus.mem_wreg = 1'b0;
        bus.mem_rd = 5'd0;
        gen_program();
        build_trace();

        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst0");
        running = 1'b1;
        rst = 1'b0;

        for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(negedge clk);
        chk("trace_drained", 64'(exp_q.size()), 64'd0);
        running = 1'b0;

        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (bus.id_state == 2'd2) found = 1'b1;
        end
        chk("stall_reached", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_stall");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("state_after_release", 64'(bus.id_state), 64'd0);
        @(posedge clk);
        #1;
        chk("state_first_edge", 64'(bus.id_state), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Instruction-decode front end of the stall-based 5-stage pipelined CPU. Holds the IF/ID pipeline register and detects read-after-write hazards against the EX and MEM stages. It drives the stall request `id_wpcir` back to the fetch stage, resolves BEQ/BNE/J in ID, and supplies `ctrl_branch`/`nid_pc` for the fetch redirect. On a stall it injects bubbles into ID/EX. On a taken branch or jump it flushes the IF/ID register.

## Interface
Parameters:
- `PC_W`, 32, width of PC and `pc4` (word-addressed PC, +1 per instruction)
- `CNT_W`, 16, width of the stall counter (only with `ID_STALL_CNT_EN`)

Ports:
- `clk` in 1: pipeline clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `if_inst` in 32: instruction fetched in IF
- `if_pc4` in PC_W: PC+1 of the fetched instruction
- `rf_qa` in 32: register-file read data for rs
- `rf_qb` in 32: register-file read data for rt
- `ex_wreg` in 1: EX-stage instruction writes a register
- `ex_rd` in 5: EX-stage destination register
- `mem_wreg` in 1: MEM-stage instruction writes a register
- `mem_rd` in 5: MEM-stage destination register
- `id_inst` out 32: IF/ID instruction register
- `id_pc4` out PC_W: IF/ID PC+1 register
- `id_valid` out 1: IF/ID holds a real instruction
- `id_bubble` out 1: ID/EX must load a NOP (all write enables 0)
- `id_wpcir` out 1: stall request; PC and IF/ID hold
- `ctrl_branch` out 1: redirect fetch to `nid_pc`
- `nid_pc` out PC_W: branch/jump target
- `id_state` out 2: FSM state
- `id_stall_cnt` out CNT_W: only with `ID_STALL_CNT_EN`

## Operation
- **Source use.**
  - rs is read by: R-type except SLL/SRL/SRA, ADDI, ANDI, ORI, LW, SW, BEQ, BNE.
  - rt is read by: R-type, SW, BEQ, BNE.
  - J reads neither.
- **Hazard.** `hz` is true when `id_valid` is set, a source is used, that source is not $0, and either:
  - (`ex_wreg` and `ex_rd` == source), or
  - (`mem_wreg` and `mem_rd` == source).
- **No WB check.** WB is not checked because the register file writes before it reads in the same cycle.
- **Stall outputs.** `id_wpcir` = `hz`. `id_bubble` = `hz` | !`id_valid`.
- **Branch resolution.** Evaluated only when `id_valid` and !`hz`.
  - BEQ is taken if `rf_qa` == `rf_qb`. BNE is taken if they differ. J is always taken.
  - BEQ/BNE target: `nid_pc` = `id_pc4` + sign-extended imm16 (word offset).
  - J target: `nid_pc` = {`id_pc4`[PC_W-1:26], `inst`[25:0]}.
  - Otherwise `nid_pc` = 0.
  - `ctrl_branch` = taken. There is no delay slot.
- **IF/ID update** on the rising clock edge, in priority order:
  1. `hz`: hold all fields.
  2. `ctrl_branch`: load `inst` = 0, `valid` = 0 (flush).
  3. Otherwise: load `if_inst`, `if_pc4`, `valid` = 1.
- **FSM states** are `FILL` (0), `RUN` (1), `STALL` (2).
  - After reset the FSM is in `FILL`. `FILL` always goes to `RUN` on the next edge.
  - `RUN` goes to `STALL` when `hz` is true.
  - `STALL` returns to `RUN` when `hz` is false, and stays in `STALL` while `hz` holds.
  - A branch is never resolved in a cycle where `hz` is true.

## Timing
- **Reset values.** `rst` asserted at any time, including mid-stall or mid-flush, immediately forces:
  - `id_inst` = 0, `id_pc4` = 0, `id_valid` = 0, `id_state` = FILL, `id_stall_cnt` = 0.
  - Combinationally: `id_wpcir` = 0, `ctrl_branch` = 0, `nid_pc` = 0, `id_bubble` = 1.
- **Combinational outputs.** `id_wpcir`, `ctrl_branch`, `nid_pc` and `id_bubble` are combinational in the same cycle.
- **Registered outputs.** `id_inst`, `id_pc4`, `id_valid` and `id_state` change one edge later.
- **Stall length.**
  - Producer in EX: 2 stall cycles.
  - Producer in MEM: 1 stall cycle.
  - Both stages matching: bounded by the EX case, i.e. 2 cycles.
- **Branch during stall.** A branch whose operands are pending waits out the stall, then redirects in the first non-hazard cycle.
- **Flush.** A taken branch or jump costs exactly 1 bubble, via the flushed IF/ID register.

## Configuration
- **`ID_STALL_CNT_EN` defined.**
  - `id_stall_cnt` exists and increments on every edge where `hz` is true.
  - It saturates at all-ones and is cleared by `rst`.
- **`ID_STALL_CNT_EN` undefined.**
  - The port and the counter are absent.
  - All other behaviour is identical.

## Structure
- The shared definitions file holds:
  - `OP_*` and `FUNC_*` opcode/function codes (the same ones used by fetch).
  - FSM state encodings `ID_ST_FILL`, `ID_ST_RUN`, `ID_ST_STALL`.
- One sub-module, `id_src_decode`: combinational, takes `inst` and produces `uses_rs`, `uses_rt`, `is_beq`, `is_bne`, `is_j`, `imm_sext`.

## Test plan
- **Reset mid-stall.**
  - Stimulus: `rst` pulsed while in `STALL`.
  - Response: all outputs at reset values at once; `id_state` is 0, then 1 after the first edge following release.
- **EX/MEM hazard.**
  - Stimulus: `add $3,$1,$2` followed by `sub $4,$3,$1`.
  - Response: `id_wpcir` = 1 and `id_bubble` = 1 for 2 cycles; `sub` then issues; counter = 2 with the macro.
- **BEQ taken.**
  - Stimulus: `beq $1,$2,+4` with `id_pc4` = 5 and `rf_qa` = `rf_qb` = 7.
  - Response: `ctrl_branch` = 1, `nid_pc` = 9; next cycle `id_valid` = 0.
- **BNE not taken.**
  - Stimulus: `bne` with `rf_qa` = `rf_qb`.
  - Response: `ctrl_branch` = 0; IF/ID loads normally.
- **Jump.**
  - Stimulus: `j 0x20` with `id_pc4` = 0x0C.
  - Response: `nid_pc` = 0x20, `ctrl_branch` = 1.
- **No hazard on $0.**
  - Stimulus: `ex_rd` = 0 with `ex_wreg` = 1, and a consumer reading $0.
  - Response: `id_wpcir` stays 0.
